matmul_job_sched: RTL

- Schedules 3x3 matrix-multiply jobs from NUM_REQ independent requesters onto one shared systolic-array instance.
- Arbitrates round-robin and latches the winner's A/B operands.
- Sequences the array's level-sensitive start/valid protocol: holds start until valid, then drops start and waits for valid to clear.
- Returns the product, with requester ID and a timeout error flag, on a single valid/ready response channel.

---
 rtl/matmul_pkg.sv | 20 ++
 rtl/matmul_job_sched_rr_arbiter.sv | 47 ++++
 rtl/matmul_job_sched.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared constants, FSM state type and element addressing for the 3x3 matmul job scheduler.
package matmul_pkg;

  localparam int DIM    = 3;
  localparam int DATA_W = 8;
  localparam int MAT_W  = DIM * DIM * DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    DRAIN,
    RESP
  } state_t;

  // Bit offset of row-major element idx inside a packed matrix of width-bit elements.
  function automatic int elem_off(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/matmul_job_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or after the pointer,
// and moves the pointer just past the winner when the grant is consumed.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] ptr;
  logic [IW:0]   cand;

  // Scan the requests starting at the pointer, wrapping once, and keep the first hit.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!any && req[cand[IW-1:0]]) begin
        any                = 1'b1;
        idx                = cand[IW-1:0];
        grant[cand[IW-1:0]] = 1'b1;
      end
    end
  end

  // Pointer moves to winner+1 (mod N) whenever a grant is actually taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && any) begin
      ptr <= (idx == IW'(N-1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/matmul_job_sched.sv
// Schedules 3x3 matmul jobs from several requesters onto one shared systolic array,
// sequencing its level start/valid handshake and returning results on one channel.
module matmul_job_sched
  import matmul_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*DIM*DIM*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*DIM*DIM*DATA_W-1:0]  req_b,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               resp_valid,
  input  logic                               resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]         resp_id,
  output logic [DIM*DIM*DATA_W-1:0]          resp_c,
  output logic                               resp_err,
  output logic                               arr_start,
  output logic [DIM*DIM*DATA_W-1:0]          arr_a,
  output logic [DIM*DIM*DATA_W-1:0]          arr_b,
  input  logic                               arr_valid,
  input  logic [DIM*DIM*DATA_W-1:0]          arr_c,
  output logic                               busy
);

  localparam int M_W   = DIM * DIM * DATA_W;
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  state_t           state;
  state_t           state_next;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_any;
  logic             advance;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (advance),
    .grant   (grant),
    .idx     (grant_idx),
    .any     (grant_any)
  );

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT-1));

  // Outputs decoded from state so they drop together with an asynchronous reset.
  assign arr_start  = (state == LAUNCH);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a valid from the array beats a timeout in the same cycle.
  always_comb begin
    state_next = state;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          advance    = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        if (arr_valid || timeout_hit) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!arr_valid) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, acceptance pulse, timeout counter and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= '0;
      arr_a     <= '0;
      arr_b     <= '0;
      resp_id   <= '0;
      resp_c    <= '0;
      resp_err  <= 1'b0;
      cnt       <= '0;
    end else begin
      req_ready <= '0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            arr_a     <= req_a[grant_idx*M_W +: M_W];
            arr_b     <= req_b[grant_idx*M_W +: M_W];
            resp_id   <= grant_idx;
            req_ready <= grant;
            cnt       <= '0;
          end
        end
        LAUNCH: begin
          if (arr_valid) begin
            resp_c   <= arr_c;
            resp_err <= 1'b0;
          end else if (timeout_hit) begin
            resp_c   <= '0;
            resp_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
